// File: rtl/bus_reader_373_pkg.sv
// Shared definitions for the '373 bus reader.
// Holds the controller state encoding, the default timing parameters
// (used by both the RTL and the testbench), and the helper that turns a
// source number into its active-low output-enable pattern.
package bus_reader_373_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Default timing: cycles a source is enabled before sampling, and the
    // idle gap with every source disabled after a completed read.
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int DEF_TURNAROUND    = 1;

    // Active-low enable pattern with only the selected source's bit low.
    function automatic logic [7:0] oe_for_addr(input logic [2:0] a);
        return ~(8'b0000_0001 << a);
    endfunction

endpackage

// File: rtl/delay_counter.sv
// delay_counter: 4-bit loadable down-counter with a zero flag.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset, clears the count
//   load       - load load_value on this edge (wins over dec)
//   load_value - value to load
//   dec        - decrement on this edge; saturates at zero
//   zero       - count is currently zero
module delay_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count_r;

    // Count register: reset, load, or saturating decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= load_value;
        end else if (dec && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == 4'd0);

endmodule

// File: rtl/bus_reader_373.sv
// bus_reader_373: reads one byte at a time from eight '373-style latches
// sharing a tristate bus. A request selects a source, its output enable is
// held low for SETTLE_CYCLES cycles, the bus is captured, and the result is
// held until acknowledged, followed by TURNAROUND idle cycles.
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous active-high reset
//   req     - read request, accepted only while ready=1
//   addr    - source select, captured with req
//   ready   - controller idle, a request may be accepted
//   bus_in  - shared data bus
//   oe_n    - per-source active-low output enables
//   data    - last captured bus value
//   valid   - data holds a completed, unacknowledged read
//   ack     - consumer accepts data (only meaningful while valid=1)
module bus_reader_373
    import bus_reader_373_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int TURNAROUND    = DEF_TURNAROUND
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [2:0] addr,
    output logic       ready,
    input  logic [7:0] bus_in,
    output logic [7:0] oe_n,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack
);

    // The shared counter is loaded with (cycles - 1): the state is left on
    // the edge where the counter already reads zero, so a load of N-1 gives
    // exactly N cycles in DRIVE or GAP.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] TURN_LOAD   = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;
    localparam bit         HAS_GAP     = (TURNAROUND > 0);

    state_t     state_r;
    logic       ready_r;
    logic [7:0] oe_n_r;
    logic [7:0] data_r;
    logic       valid_r;

    logic       cnt_load_s;
    logic [3:0] cnt_load_val_s;
    logic       cnt_dec_s;
    logic       cnt_zero_s;

    delay_counter u_delay_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load_s),
        .load_value (cnt_load_val_s),
        .dec        (cnt_dec_s),
        .zero       (cnt_zero_s)
    );

    // Counter control: load on entry to a timed state, count down inside it.
    always_comb begin
        cnt_load_s     = 1'b0;
        cnt_load_val_s = 4'd0;
        cnt_dec_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = SETTLE_LOAD;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (!cnt_zero_s) begin
                    cnt_dec_s = 1'b1;
                end else begin
                    cnt_dec_s = 1'b0;
                end
            end
            ST_HOLD: begin
                if (ack) begin
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = TURN_LOAD;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            ST_GAP: begin
                if (!cnt_zero_s) begin
                    cnt_dec_s = 1'b1;
                end else begin
                    cnt_dec_s = 1'b0;
                end
            end
            default: begin
                cnt_load_s = 1'b0;
                cnt_dec_s  = 1'b0;
            end
        endcase
    end

    // Controller FSM with all outputs registered. The selected source is
    // kept only in decoded form (oe_n_r), so later addr changes have no effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            oe_n_r  <= 8'hFF;
            data_r  <= 8'h00;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        oe_n_r  <= oe_for_addr(addr);
                        ready_r <= 1'b0;
                        state_r <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_zero_s) begin
                        data_r  <= bus_in;
                        valid_r <= 1'b1;
                        oe_n_r  <= 8'hFF;
                        state_r <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // ack can only be seen here, i.e. after valid is already high.
                    if (ack) begin
                        valid_r <= 1'b0;
                        if (HAS_GAP) begin
                            state_r <= ST_GAP;
                        end else begin
                            state_r <= ST_IDLE;
                            ready_r <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_zero_s) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    oe_n_r  <= 8'hFF;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_r;
    assign oe_n  = oe_n_r;
    assign data  = data_r;
    assign valid = valid_r;

endmodule

// File: doc/bus_reader_373.md
BUS_READER_373 -- requirements
Module: bus_reader_373

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, number of clock cycles a source's output enable is held low before the bus is sampled (legal range 1..15).
REQ-002 SHALL have parameter TURNAROUND, default 1, number of idle cycles with all output enables high after a completed read (legal range 0..15).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  1  read request, sampled only while ready=1.
REQ-006 SHALL have port addr  input  3  source select (0..7), captured with req.
REQ-007 SHALL have port ready  output  1  high only in IDLE; request may be accepted.
REQ-008 SHALL have port bus_in  input  8  shared tristate data bus driven by '373-style latches.
REQ-009 SHALL have port oe_n  output  8  per-source active-low output enables, bit i drives source i's OC pin.
REQ-010 SHALL have port data  output  8  captured bus value.
REQ-011 SHALL have port valid  output  1  data holds a completed read.
REQ-012 SHALL have port ack  input  1  consumer accepts data; effective only when valid=1.

Function
REQ-013 SHALL implement states IDLE, DRIVE, HOLD, GAP; all outputs registered.
REQ-014 IDLE: ready=1, oe_n=8'hFF; on an edge with req=1, SHALL latch addr, load settle counter with SETTLE_CYCLES, enter DRIVE.
REQ-015 DRIVE: oe_n SHALL equal ~(1<<addr_latched) for exactly SETTLE_CYCLES cycles; counter decrements each edge.
REQ-016 On the edge ending the last DRIVE cycle, SHALL set data<=bus_in, valid<=1, oe_n<=8'hFF, enter HOLD (req-accept edge to valid high = SETTLE_CYCLES edges).
REQ-017 HOLD: data and valid SHALL remain stable until an edge with ack=1; that edge clears valid and enters GAP (TURNAROUND>0) or IDLE (TURNAROUND=0).
REQ-018 GAP: oe_n=8'hFF, ready=0 for exactly TURNAROUND cycles, then IDLE.
REQ-019 req while ready=0 SHALL be ignored, not queued; addr changes outside the accept edge SHALL have no effect.
REQ-020 ack while valid=0 SHALL be ignored; ack on the same edge valid rises SHALL NOT clear it.
REQ-021 At most one oe_n bit SHALL be low in any cycle; none low outside DRIVE.
REQ-022 data SHALL retain the last captured value through GAP and IDLE until the next capture.

Reset
REQ-023 On an edge with reset=1, regardless of state (including mid-DRIVE), SHALL force IDLE, oe_n=8'hFF, valid=0, data=8'h00, counters=0; ready=1 from the following cycle.
REQ-024 reset SHALL take priority over req and ack on the same edge.

Structure
REQ-025 State encodings and default SETTLE_CYCLES/TURNAROUND values SHALL live in a shared include header used by RTL and bench.
REQ-026 SHALL instantiate one sub-module, delay_counter (4-bit loadable down-counter with zero flag), reused for settle and turnaround timing.

Verification
REQ-027 Single read: SETTLE=2, req addr=3, bus_in=8'hA5 -> oe_n=8'hF7 for 2 cycles, then valid=1, data=8'hA5, oe_n=8'hFF.
REQ-028 Hold: delay ack 10 cycles while bus_in changes to 8'h5A -> data stays 8'hA5, valid stays 1; ack -> valid 0, ready 0 one cycle (GAP), then ready 1.
REQ-029 Sweep addr 0..7 with bus_in=addr*8'h11 -> each oe_n has only bit addr low, data equals addr*8'h11, one-hot-low invariant never violated.
REQ-030 Reset mid-DRIVE: assert reset on first DRIVE cycle -> next cycle oe_n=8'hFF, valid=0, data=8'h00, ready=1.
REQ-031 Ignored inputs: req pulsed during HOLD/GAP and ack in IDLE -> no state change, no extra oe_n activity.
REQ-032 TURNAROUND=0, SETTLE=1: back-to-back reads addr 0 then 7 -> valid after 1 edge each, ready high the cycle after ack.
